// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, MMIO read mux and cycle/instret counters (branch stats via MEM_WB_BRANCH_STATS_EN).
// Latency: an instruction in MEM at edge N drives the regfile write port during cycle N+1.
// Backpressure: stall holds the WB slot; retirement counting and the UART RX pop wait for the slot to advance.
`ifndef WBSEL_ALU_OUT
`define WBSEL_ALU_OUT 2'b00
`endif
`ifndef WBSEL_DATA_OUT
`define WBSEL_DATA_OUT 2'b01
`endif
`ifndef WBSEL_PC_PLUS_4
`define WBSEL_PC_PLUS_4 2'b10
`endif
`ifndef OPC_STORE
`define OPC_STORE 7'b0100011
`endif

module mem_wb_stage #(
    parameter int unsigned CWIDTH       = 32,
    parameter logic [31:0] CNT_RST_ADDR = 32'h8000_0018
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        valid_mem,
    input  logic [31:0] inst_mem,
    input  logic [31:0] alu_mem,
    input  logic [31:0] pc_mem,
    input  logic [3:0]  ld_mask,
    input  logic        ld_sign,
    input  logic [2:0]  io_sel,
    input  logic [1:0]  wb_sel,
    input  logic        reg_wen,
`ifdef MEM_WB_BRANCH_STATS_EN
    input  logic        br_resolved_mem,
    input  logic        br_taken_mem,
`endif
    input  logic [31:0] dmem_dout,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    input  logic        uart_tx_ready,
    output logic        uart_rx_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_wen
);

    localparam logic [2:0] IO_UART_CTRL = 3'd1;
    localparam logic [2:0] IO_UART_DATA = 3'd2;
    localparam logic [2:0] IO_CYCLE     = 3'd3;
    localparam logic [2:0] IO_INSTRET   = 3'd4;
`ifdef MEM_WB_BRANCH_STATS_EN
    localparam logic [2:0] IO_BR_TOTAL  = 3'd5;
    localparam logic [2:0] IO_BR_TAKEN  = 3'd6;
`endif

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [3:0]  ld_mask;
        logic        ld_sign;
        logic [2:0]  io_sel;
        logic [1:0]  wb_sel;
        logic        reg_wen;
`ifdef MEM_WB_BRANCH_STATS_EN
        logic        br_resolved;
        logic        br_taken;
`endif
    } slot_t;

    slot_t              slot_q, slot_d;
    logic [CWIDTH-1:0]  cycle_q, cycle_d;
    logic [CWIDTH-1:0]  instret_q, instret_d;
    logic               retire;
    logic               cnt_clr;
    logic [31:0]        load_data;
    logic [31:0]        data_out;
    logic               unused_inst;

    assign unused_inst = ^inst_mem[31:12];

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
        return {{24{s & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
        return {{16{s & h[15]}}, h};
    endfunction

    always_comb begin
        slot_d = slot_q;
        if (!stall) begin
            slot_d.valid   = valid_mem;
            slot_d.rd      = inst_mem[11:7];
            slot_d.alu     = alu_mem;
            slot_d.pc4     = pc_mem + 32'd4;
            slot_d.ld_mask = ld_mask;
            slot_d.ld_sign = ld_sign;
            slot_d.io_sel  = io_sel;
            slot_d.wb_sel  = wb_sel;
            slot_d.reg_wen = reg_wen;
`ifdef MEM_WB_BRANCH_STATS_EN
            slot_d.br_resolved = br_resolved_mem;
            slot_d.br_taken    = br_taken_mem;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Retirement is the WB slot advancing; the clear is decoded from the store still in MEM.
    assign retire  = slot_q.valid & ~stall;
    assign cnt_clr = valid_mem & ~stall & (inst_mem[6:0] == `OPC_STORE) & (alu_mem == CNT_RST_ADDR);

    always_comb begin
        cycle_d   = cycle_q + CWIDTH'(1);
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CWIDTH'(1);
        end
        if (cnt_clr) begin
            cycle_d   = '0;
            instret_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

`ifdef MEM_WB_BRANCH_STATS_EN
    logic [CWIDTH-1:0] br_total_q, br_total_d;
    logic [CWIDTH-1:0] br_taken_q, br_taken_d;

    always_comb begin
        br_total_d = br_total_q;
        br_taken_d = br_taken_q;
        if (retire && slot_q.br_resolved) begin
            br_total_d = br_total_q + CWIDTH'(1);
            if (slot_q.br_taken) begin
                br_taken_d = br_taken_q + CWIDTH'(1);
            end
        end
        if (cnt_clr) begin
            br_total_d = '0;
            br_taken_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q <= '0;
            br_taken_q <= '0;
        end else begin
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end
`endif

    // Mask 4'b1000 is a byte load even when the op was LH; misaligned halfwords are outside the ISA contract.
    always_comb begin
        load_data = '0;
        case (slot_q.ld_mask)
            4'b1111: load_data = dmem_dout;
            4'b0001: load_data = ext8(dmem_dout[7:0],   slot_q.ld_sign);
            4'b0010: load_data = ext8(dmem_dout[15:8],  slot_q.ld_sign);
            4'b0100: load_data = ext8(dmem_dout[23:16], slot_q.ld_sign);
            4'b1000: load_data = ext8(dmem_dout[31:24], slot_q.ld_sign);
            4'b0011: load_data = ext16(dmem_dout[15:0],  slot_q.ld_sign);
            4'b0110: load_data = ext16(dmem_dout[23:8],  slot_q.ld_sign);
            4'b1100: load_data = ext16(dmem_dout[31:16], slot_q.ld_sign);
            default: load_data = '0;
        endcase
    end

    always_comb begin
        data_out = load_data;
        case (slot_q.io_sel)
            IO_UART_CTRL: data_out = {30'b0, uart_rx_valid, uart_tx_ready};
            IO_UART_DATA: data_out = {24'b0, uart_rx_data};
            IO_CYCLE:     data_out = 32'(cycle_q);
            IO_INSTRET:   data_out = 32'(instret_q);
`ifdef MEM_WB_BRANCH_STATS_EN
            IO_BR_TOTAL:  data_out = 32'(br_total_q);
            IO_BR_TAKEN:  data_out = 32'(br_taken_q);
`endif
            default:      data_out = load_data;
        endcase
    end

    always_comb begin
        case (slot_q.wb_sel)
            `WBSEL_DATA_OUT:  wb_data = data_out;
            `WBSEL_PC_PLUS_4: wb_data = slot_q.pc4;
            default:          wb_data = slot_q.alu;
        endcase
    end

    assign wb_rd         = slot_q.rd;
    assign wb_wen        = slot_q.valid & slot_q.reg_wen & (slot_q.rd != 5'd0);
    assign uart_rx_ready = slot_q.valid & ~stall & (slot_q.wb_sel == `WBSEL_DATA_OUT)
                           & (slot_q.io_sel == IO_UART_DATA);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a field-level reference model.
module tb_mem_wb_stage;

    localparam logic [31:0] CNT_RST_ADDR = 32'h8000_0018;
    localparam logic [6:0]  OPC_STORE    = 7'b0100011;
    localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [1:0]  WB_ALU       = 2'd0;
    localparam logic [1:0]  WB_DATA      = 2'd1;
    localparam logic [1:0]  WB_PC4       = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        valid_mem;
    logic [31:0] inst_mem;
    logic [31:0] alu_mem;
    logic [31:0] pc_mem;
    logic [3:0]  ld_mask;
    logic        ld_sign;
    logic [2:0]  io_sel;
    logic [1:0]  wb_sel;
    logic        reg_wen;
    logic [31:0] dmem_dout;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_tx_ready;
    logic        uart_rx_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;

    mem_wb_stage #(.CWIDTH(32), .CNT_RST_ADDR(CNT_RST_ADDR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .valid_mem     (valid_mem),
        .inst_mem      (inst_mem),
        .alu_mem       (alu_mem),
        .pc_mem        (pc_mem),
        .ld_mask       (ld_mask),
        .ld_sign       (ld_sign),
        .io_sel        (io_sel),
        .wb_sel        (wb_sel),
        .reg_wen       (reg_wen),
`ifdef MEM_WB_BRANCH_STATS_EN
        .br_resolved_mem(1'b0),
        .br_taken_mem  (1'b0),
`endif
        .dmem_dout     (dmem_dout),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_ready (uart_rx_ready),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_wen        (wb_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit [4:0]    rd;
        bit [31:0]   alu;
        bit [31:0]   pc4;
        bit [3:0]    mask;
        bit          sign;
        bit [2:0]    io;
        bit [1:0]    wbs;
        bit          wen;
    } slot_m_t;

    slot_m_t   m_slot;
    bit [31:0] m_cyc;
    bit [31:0] m_ins;
    int        n_err;
    int        n_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [6:0] opc);
        return {20'h0, rd, opc};
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [3:0] mask, input bit sign);
        int k;
        int n;
        int w;
        logic [31:0] s;
        k = -1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                n++;
                if (k < 0) k = i;
            end
        end
        if (mask == 4'b1111) return d;
        if (n == 1) w = 8;
        else if (n == 2 && int'(mask) == (3 << k)) w = 16;
        else return 32'h0;
        s = d >> (8 * k);
        s = s & ((32'd1 << w) - 32'd1);
        if (sign && s[w-1]) s = s | ~((32'd1 << w) - 32'd1);
        return s;
    endfunction

    function automatic logic [31:0] m_data();
        if (m_slot.wbs == WB_DATA) begin
            case (m_slot.io)
                3'd1: return {30'b0, uart_rx_valid, uart_tx_ready};
                3'd2: return {24'b0, uart_rx_data};
                3'd3: return m_cyc;
                3'd4: return m_ins;
`ifdef MEM_WB_BRANCH_STATS_EN
                3'd5, 3'd6: return 32'h0;
`endif
                default: return m_load(dmem_dout, m_slot.mask, m_slot.sign);
            endcase
        end
        if (m_slot.wbs == WB_PC4) return m_slot.pc4;
        return m_slot.alu;
    endfunction

    task automatic check_all(input string tag);
        bit exp_wen;
        bit exp_rdy;
        exp_wen = m_slot.valid && m_slot.wen && (m_slot.rd != 5'd0);
        exp_rdy = m_slot.valid && (m_slot.wbs == WB_DATA) && (m_slot.io == 3'd2) && !stall;
        check({tag, "/data"}, wb_data, m_data());
        check({tag, "/wen"}, 32'(wb_wen), 32'(exp_wen));
        check({tag, "/rd"}, 32'(wb_rd), 32'(m_slot.rd));
        check({tag, "/rx_rdy"}, 32'(uart_rx_ready), 32'(exp_rdy));
    endtask

    task automatic model_reset();
        m_slot = '{default: 0};
        m_cyc  = 32'h0;
        m_ins  = 32'h0;
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [3:0] mask, input bit sign,
                         input logic [2:0] io, input logic [1:0] wbs, input bit wen);
        valid_mem = v;
        inst_mem  = inst;
        alu_mem   = alu;
        pc_mem    = pc;
        ld_mask   = mask;
        ld_sign   = sign;
        io_sel    = io;
        wb_sel    = wbs;
        reg_wen   = wen;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 3'd0, WB_ALU, 1'b0);
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        bit clr;
        clr = valid_mem && (inst_mem[6:0] == OPC_STORE) && (alu_mem == CNT_RST_ADDR) && !stall;
        if (clr) m_ins = 32'h0;
        else if (m_slot.valid && !stall) m_ins = m_ins + 32'd1;
        m_cyc = clr ? 32'h0 : m_cyc + 32'd1;
        if (!stall) begin
            m_slot.valid = valid_mem;
            m_slot.rd    = inst_mem[11:7];
            m_slot.alu   = alu_mem;
            m_slot.pc4   = pc_mem + 32'd4;
            m_slot.mask  = ld_mask;
            m_slot.sign  = ld_sign;
            m_slot.io    = io_sel;
            m_slot.wbs   = wb_sel;
            m_slot.wen   = reg_wen;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input string tag, input logic [3:0] mask, input bit sign,
                            input logic [31:0] dout, input logic [31:0] exp);
        drive(1'b1, mk_inst(5'd3, OPC_LOAD), 32'h0000_1000, 32'h40, mask, sign, 3'd0, WB_DATA, 1'b1);
        tick();
        bubble();
        dmem_dout = dout;
        #1;
        check(tag, wb_data, exp);
        check_all({tag, "_model"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b1;
        stall = 1'b0;
        bubble();
        dmem_dout     = 32'h0;
        uart_rx_data  = 8'h0;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("reset/data", wb_data, 32'h0);
        check("reset/wen", 32'(wb_wen), 32'h0);
        check("reset/rd", 32'(wb_rd), 32'h0);
        check("reset/rx_rdy", 32'(uart_rx_ready), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("idle");
        end
        drive(1'b1, mk_inst(5'd5, OPC_LOAD), CNT_RST_ADDR - 32'd8, 32'h200, 4'b1111, 1'b0, 3'd3, WB_DATA, 1'b1);
        tick();
        bubble();
        #1;
        check_all("cycle_read");

        load_vec("lb_off3",  4'b1000, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80);
        load_vec("lbu_off3", 4'b1000, 1'b0, 32'h80FF_1234, 32'h0000_0080);
        load_vec("lh_off2",  4'b1100, 1'b1, 32'h8001_0000, 32'hFFFF_8001);
        load_vec("lw",       4'b1111, 1'b1, 32'h8001_0000, 32'h8001_0000);
        load_vec("mask0101", 4'b0101, 1'b1, 32'h8001_0000, 32'h0000_0000);
        load_vec("mask0000", 4'b0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
        load_vec("lhu_off1", 4'b0110, 1'b0, 32'h1234_5678, 32'h0000_3456);
        load_vec("lb_off0",  4'b0001, 1'b1, 32'h0000_00F0, 32'hFFFF_FFF0);

        drive(1'b1, mk_inst(5'd0, OPC_STORE), CNT_RST_ADDR, 32'h300, 4'b1111, 1'b0, 3'd0, WB_ALU, 1'b0);
        tick();
        drive(1'b1, mk_inst(5'd6, OPC_LOAD), CNT_RST_ADDR - 32'd8, 32'h304, 4'b1111, 1'b0, 3'd3, WB_DATA, 1'b1);
        #1;
        check_all("clr_store");
        tick();
        drive(1'b1, mk_inst(5'd7, OPC_LOAD), CNT_RST_ADDR - 32'd4, 32'h308, 4'b1111, 1'b0, 3'd4, WB_DATA, 1'b1);
        #1;
        check("clr_cycle", wb_data, 32'd1);
        check_all("clr_cycle_model");
        tick();
        bubble();
        #1;
        check_all("clr_instret");

        uart_rx_data = 8'hA5;
        drive(1'b1, mk_inst(5'd8, OPC_LOAD), 32'h8000_0008, 32'h400, 4'b1111, 1'b0, 3'd2, WB_DATA, 1'b1);
        tick();
        bubble();
        stall = 1'b1;
        #1;
        check("uart_stall_rdy", 32'(uart_rx_ready), 32'h0);
        check_all("uart_stall");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("uart_hold_rdy", 32'(uart_rx_ready), 32'h0);
            check_all("uart_hold");
        end
        stall = 1'b0;
        #1;
        check("uart_pulse", 32'(uart_rx_ready), 32'h1);
        check("uart_data", wb_data, 32'h0000_00A5);
        tick();
        check("uart_after", 32'(uart_rx_ready), 32'h0);
        check_all("uart_after");

        drive(1'b1, mk_inst(5'd1, OPC_JAL), 32'h0, 32'h100, 4'h0, 1'b0, 3'd0, WB_PC4, 1'b1);
        tick();
        drive(1'b1, mk_inst(5'd0, OPC_JAL), 32'h0, 32'h100, 4'h0, 1'b0, 3'd0, WB_PC4, 1'b1);
        #1;
        check("jal_data", wb_data, 32'h104);
        check("jal_wen", 32'(wb_wen), 32'h1);
        tick();
        bubble();
        #1;
        check("jal_rd0_wen", 32'(wb_wen), 32'h0);
        check_all("jal_rd0");
        tick();
        drive(1'b1, mk_inst(5'd9, OPC_LOAD), 32'h0, 32'h500, 4'b1111, 1'b0, 3'd4, WB_DATA, 1'b1);
        #1;
        check("bubble_wen", 32'(wb_wen), 32'h0);
        tick();
        bubble();
        #1;
        check_all("bubble_instret");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] inst;
            inst = $urandom;
            if ($urandom_range(0, 3) == 0) inst[6:0] = OPC_STORE;
            drive($urandom_range(0, 3) != 0, inst,
                  ($urandom_range(0, 7) == 0) ? CNT_RST_ADDR : $urandom, $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom));
            stall         = ($urandom_range(0, 4) == 0);
            dmem_dout     = $urandom;
            uart_rx_data  = 8'($urandom);
            uart_rx_valid = 1'($urandom);
            uart_tx_ready = 1'($urandom);
            #1;
            check_all("rand");
            tick();
        end
        stall = 1'b0;

        uart_rx_data = 8'h3C;
        drive(1'b1, mk_inst(5'd9, OPC_LOAD), 32'h8000_0008, 32'h600, 4'b1111, 1'b0, 3'd2, WB_DATA, 1'b1);
        tick();
        bubble();
        #1;
        check_all("pre_rst");
        #1 rst_n = 1'b0;
        #1;
        check("rst_wen", 32'(wb_wen), 32'h0);
        check("rst_rx_rdy", 32'(uart_rx_ready), 32'h0);
        check("rst_data", wb_data, 32'h0);
        check("rst_rd", 32'(wb_rd), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, mk_inst(5'd10, OPC_LOAD), 32'h0, 32'h700, 4'b1111, 1'b0, 3'd4, WB_DATA, 1'b1);
        tick();
        drive(1'b1, mk_inst(5'd11, OPC_LOAD), 32'h0, 32'h704, 4'b1111, 1'b0, 3'd3, WB_DATA, 1'b1);
        #1;
        check("post_rst_instret", wb_data, 32'h0);
        check_all("post_rst_instret_model");
        tick();
        bubble();
        #1;
        check_all("post_rst_cycle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
